// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target for the 68k local bus, with an RX FIFO, a TX holding register and sticky error flags.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module spi_target #(
  parameter int          RX_DEPTH = 4,
  parameter logic [7:0]  TX_FILL  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_write,
  output logic [15:0] data_read,
  input  logic [7:0]  addr,
  input  logic        uds,
  input  logic        lds,
  input  logic        rw,
  output logic        ack,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [2:0]  sck_sync_q, cs_sync_q;
  logic [1:0]  mosi_sync_q;
  logic        req_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic        miso_q;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic        tx_pending_q, tx_pending_d;
  logic        overrun_q, overrun_d;
  logic        underrun_q, underrun_d;
  logic        irq_en_q, irq_en_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]  mem_q [RX_DEPTH];
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q;

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;
  logic req, strobe, wr_data, rd_data, wr_stat, rd_stat;
  logic shifting, sample, shift_out, reload, push_req, push, pop, full, nonempty;
  logic [7:0] rx_byte, status;

  // Bits of the bus that carry no information for this block.
  logic unused_ok;
  assign unused_ok = ^{data_write[15:8], addr[0]};

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];

  assign req     = uds | lds;
  assign strobe  = req & ~req_q;
  assign wr_data = strobe & ~rw & (addr[7:1] == 7'd0);
  assign rd_data = strobe &  rw & (addr[7:1] == 7'd0);
  assign wr_stat = strobe & ~rw & (addr[7:1] == 7'd1);
  assign rd_stat = strobe &  rw & (addr[7:1] == 7'd1);

  assign full     = (count_q == CW'(RX_DEPTH));
  assign nonempty = (count_q != '0);
  assign pop      = rd_data & nonempty;

  assign sample    = (state_q == S_SHIFT) & ~cs_rise & sck_rise;
  assign shift_out = (state_q == S_SHIFT) & ~cs_rise & sck_fall & (bit_cnt_q != 3'd0);
  assign reload    = ((state_q == S_IDLE) & cs_fall) |
                     ((state_q == S_SHIFT) & ~cs_rise & sck_fall & (bit_cnt_q == 3'd0));
  assign rx_byte   = {rx_sr_q[6:0], mosi_s};
  assign push_req  = sample & (bit_cnt_q == 3'd7);
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign push      = push_req & (~full | pop);

  assign status = {1'b0, irq_en_q, shifting, underrun_q, overrun_q, ~tx_pending_q, full, nonempty};

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cs_fall) state_d = S_SHIFT;
      S_SHIFT: if (cs_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    shifting    = (state_q == S_SHIFT);
    spi_miso_oe = shifting;
    spi_miso    = shifting & miso_q;
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    rx_sr_d      = rx_sr_q;
    tx_sr_d      = tx_sr_q;
    tx_hold_d    = tx_hold_q;
    tx_pending_d = tx_pending_q;
    overrun_d    = overrun_q;
    underrun_d   = underrun_q;
    irq_en_d     = irq_en_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    rdata_d      = 16'h0000;

    if (cs_rise || state_q == S_IDLE) bit_cnt_d = 3'd0;
    else if (sample)                  bit_cnt_d = bit_cnt_q + 3'd1;

    if (cs_rise)     rx_sr_d = 8'h00;
    else if (sample) rx_sr_d = rx_byte;

    // A reload takes the byte held before any same-cycle bus write.
    if (cs_rise)        tx_sr_d = 8'h00;
    else if (reload)    tx_sr_d = tx_pending_q ? tx_hold_q : TX_FILL;
    else if (shift_out) tx_sr_d = {tx_sr_q[6:0], 1'b0};

    if (wr_data) begin
      tx_hold_d    = data_write[7:0];
      tx_pending_d = 1'b1;
    end else if (reload) begin
      tx_pending_d = 1'b0;
    end

    if (push_req & full & ~pop)       overrun_d = 1'b1;
    else if (wr_stat & data_write[3]) overrun_d = 1'b0;

    if (reload & ~tx_pending_q)       underrun_d = 1'b1;
    else if (wr_stat & data_write[4]) underrun_d = 1'b0;

    if (wr_stat) irq_en_d = data_write[6];

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (rd_data)      rdata_d = {8'h00, pop ? mem_q[rd_ptr_q] : 8'h00};
    else if (rd_stat) rdata_d = {8'h00, status};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q   <= 3'b000;
      cs_sync_q    <= 3'b111;
      mosi_sync_q  <= 2'b00;
      req_q        <= 1'b0;
      bit_cnt_q    <= 3'd0;
      rx_sr_q      <= 8'h00;
      tx_sr_q      <= 8'h00;
      miso_q       <= 1'b0;
      tx_hold_q    <= 8'h00;
      tx_pending_q <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      irq_en_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rdata_q      <= 16'h0000;
      ack_q        <= 1'b0;
    end else begin
      sck_sync_q   <= {sck_sync_q[1:0], spi_sck};
      cs_sync_q    <= {cs_sync_q[1:0], spi_cs_n};
      mosi_sync_q  <= {mosi_sync_q[0], spi_mosi};
      req_q        <= req;
      bit_cnt_q    <= bit_cnt_d;
      rx_sr_q      <= rx_sr_d;
      tx_sr_q      <= tx_sr_d;
      miso_q       <= tx_sr_q[7];
      tx_hold_q    <= tx_hold_d;
      tx_pending_q <= tx_pending_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      irq_en_q     <= irq_en_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rdata_q      <= rdata_d;
      ack_q        <= strobe;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte;
  end

  assign data_read = rdata_q;
  assign ack       = ack_q;
  assign irq       = irq_en_q & (nonempty | overrun_q);

endmodule

`default_nettype wire

// File: doc/spi_target.md
# spi_target

SPI target (peripheral-side) controller: the receiving end of the team's SPI master link, letting one m68k FPGA act as an SPI device towards another SPI master. Uses SPI mode 0, MSB first, 8-bit frames, matching the master's transmit-on-falling/sample-on-rising convention. Sits on the 68k local bus with the same byte-lane register interface as the master. It provides a small RX FIFO, a TX holding register, sticky error flags and an interrupt request.

## Interface
- RX_DEPTH, 4: RX FIFO depth in bytes; power of two, at least 2.
- TX_FILL, 8'hFF: byte shifted out when no TX byte is pending.
- clk  in  1  system clock; all logic in this domain.
- reset  in  1  asynchronous, active-high reset.
- data_write  in  16  bus write data; byte lanes [15:8]=uds, [7:0]=lds.
- data_read  out  16  bus read data; unused bits 0.
- addr  in  8  byte address within block.
- uds, lds  in  1  upper/lower byte strobes; access request = uds|lds.
- rw  in  1  1=read, 0=write.
- ack  out  1  one-cycle access acknowledge.
- spi_sck  in  1  SPI clock from the external master; asynchronous.
- spi_mosi  in  1  data from the master; asynchronous.
- spi_cs_n  in  1  active-low select; asynchronous.
- spi_miso  out  1  data to the master.
- spi_miso_oe  out  1  1 while selected; drives the board tristate.
- irq  out  1  level interrupt request.

## Operation
- Synchronise spi_sck, spi_mosi and spi_cs_n with 2 flops each. A third flop on sck and cs_n feeds edge detection.
- Access strobe = (uds|lds) & ~previous(uds|lds). Each strobe yields exactly one ack and one side effect, however long the request is held.
- Register map, decoded by addr[7:1]; only the lds lane carries data:
  - 0, DATA: a read pops the RX FIFO into data_read[7:0], or returns 0 with no pop if the FIFO is empty. A write loads data_write[7:0] into TX holding and sets tx_pending. Writing while tx_pending is set overwrites the held byte.
  - 1, STATUS: read returns {0, irq_en, cs_active, underrun, overrun, tx_empty, rx_full, rx_nonempty} in [6:0]. On write, bit3=1 clears overrun, bit4=1 clears underrun, and bit6 is written to irq_en.
  - Other addresses: acked, read 0, writes ignored.
- irq = irq_en & (rx_nonempty | overrun).
- Shift engine, events taken from the synchronised signals:
  - **IDLE** (cs high): bit_cnt=0, spi_miso=0, spi_miso_oe=0.
  - **cs falling edge**: load the TX shift register from holding if tx_pending, otherwise load TX_FILL and set underrun. Clear tx_pending, drive the MSB, set oe=1, enter **SHIFT**.
  - **SHIFT, sck rising edge**: shift mosi into the RX shift register and increment bit_cnt. When bit_cnt wraps 7→0, push the assembled byte. If the FIFO is full, drop the byte and set overrun.
  - **SHIFT, sck falling edge**: if bit_cnt≠0, shift the next TX bit out. If bit_cnt=0, reload the TX shift register exactly as on the cs fall and drive the new MSB. The falling edge after the 8th rising edge therefore starts the next byte.
  - **cs rising edge**: discard the partial RX byte. The consumed TX byte is not restored. Return to IDLE.
- A bus pop and an SPI push in the same cycle both take effect; the count is unchanged. If the FIFO is full, that push succeeds because the simultaneous pop frees a slot.
- A bus TX write in the same cycle as an SPI reload: the reload takes the old held byte, and the new byte stays pending.

## Timing
- Reset values: data_read=0, ack=0, spi_miso=0, spi_miso_oe=0, irq=0. FIFO empty, tx_pending=0, flags 0, irq_en=0.
- ack is high in the cycle after the strobe and for that cycle only. data_read is valid in the same cycle as ack and is 0 in all other cycles.
- Pin-to-action latency is 3 clk for sck and cs_n edges. spi_miso changes 4 clk after the sck falling pin edge.
- Requirement: SCK high and low phases of at least 6 clk each, so master clk_div ≥ 3 when both ends share a clock rate. A cs_n setup of at least 4 clk before the first sck rising edge is also required.
- A pushed byte is visible in STATUS one cycle after the push.

## Test plan
- Reset mid-byte (after 4 bits): all outputs, FIFO and flags at reset values immediately. The next cs frame starts cleanly.
- Write DATA=0xA5, then the master sends 0x3C in one frame: spi_miso carries 0xA5 MSB first; DATA read returns 0x3C; STATUS shows rx_nonempty=1, tx_empty=1.
- Back-to-back frame of 2 bytes with no TX written: miso carries 0xFF, 0xFF and underrun=1. Writing STATUS bit4=1 clears underrun.
- Send 5 bytes 0x01..0x05 with RX_DEPTH=4: reads return 0x01..0x04, then 0; overrun=1; irq=1 when irq_en=1. Clearing overrun with the FIFO empty drops irq to 0.
- Deassert cs after 3 bits: no byte pushed; the next full frame receives the correct byte.
- Hold uds|lds for 5 cycles on a DATA read with 2 bytes queued: one ack, one pop, 1 byte remaining.
